// File: rtl/i2s_pkt_framer_pkg.sv
// Shared framer definitions: FSM states, header geometry, default magic, CRC polynomial
// and the tag byte layout that the upstream i2s_in tag generator also produces.
package i2s_pkt_framer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StPayload,
    StCrc,
    StDrop
  } state_e;

  localparam int unsigned HdrLen       = 5;
  localparam logic [7:0]  DefaultMagic = 8'h5A;
  localparam logic [7:0]  CrcPoly      = 8'h07;

  // First byte of every input frame.
  typedef struct packed {
    logic [3:0] dst;
    logic [3:0] ch;
  } tag_t;

endpackage

// File: rtl/crc8_07.sv
// Combinational CRC-8 step (poly 0x07, MSB first): next CRC from current CRC and one byte.
module crc8_07
  import i2s_pkt_framer_pkg::*;
(
  input  logic [7:0] crc_i,
  input  logic [7:0] data_i,
  output logic [7:0] crc_o
);

  logic [7:0] c;

  always_comb begin
    c = crc_i ^ data_i;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CrcPoly) : {c[6:0], 1'b0};
    end
    crc_o = c;
  end

endmodule

// File: rtl/i2s_pkt_framer.sv
// I2S frame-to-packet framer: header, per-channel sequence number, length guard.
// Define I2S_PKT_FRAMER_CRC_EN to append a CRC-8 trailer byte to every packet.
module i2s_pkt_framer
  import i2s_pkt_framer_pkg::*;
#(
  parameter int unsigned CN          = 16,
  parameter int unsigned MAX_PAYLOAD = 64,
  parameter logic [7:0]  MAGIC       = DefaultMagic
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        s_axis_tvalid,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic        m_axis_tvalid,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  input  logic        m_axis_tready,
  input  logic        i_enable,
  output logic [31:0] o_frame_count,
  output logic [15:0] o_drop_count
);

  localparam int unsigned ChW   = (CN > 1) ? $clog2(CN) : 1;
  localparam logic [7:0]  MaxPl = 8'(MAX_PAYLOAD);

  state_e      state_q;
  tag_t        tag_q;
  logic [2:0]  hdr_idx_q;
  logic [7:0]  cnt_q;
  logic [15:0] seq_q [CN];
  logic [31:0] frame_cnt_q;
  logic [15:0] drop_cnt_q;
  logic        out_valid_q, out_last_q, out_user_q;
  logic [7:0]  out_data_q;

  logic           out_free, in_ready, in_fire, tag_ok;
  tag_t           tag_in;
  logic [ChW-1:0] ch_idx;
  logic [15:0]    seq_cur;
  logic [7:0]     hdr_byte, cnt_inc;

  assign out_free = !out_valid_q || m_axis_tready;
  assign tag_in   = tag_t'(s_axis_tdata);
  assign ch_idx   = tag_q.ch[ChW-1:0];
  assign seq_cur  = seq_q[ch_idx];
  assign cnt_inc  = cnt_q + 8'd1;

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      StIdle, StPayload: in_ready = out_free;
      StDrop:            in_ready = 1'b1;
      default:           in_ready = 1'b0;
    endcase
  end

  // Gated by rst so the port reads 0 while reset is held.
  assign s_axis_tready = in_ready && !rst;
  assign in_fire       = s_axis_tvalid && s_axis_tready;
  assign tag_ok        = (state_q == StIdle) && in_fire && !s_axis_tlast &&
                         (32'(tag_in.ch) < CN) && i_enable;

  always_comb begin
    case (hdr_idx_q)
      3'd1:    hdr_byte = {4'h0, tag_q.dst};
      3'd2:    hdr_byte = {4'h0, tag_q.ch};
      3'd3:    hdr_byte = seq_cur[15:8];
      default: hdr_byte = seq_cur[7:0];
    endcase
  end

`ifdef I2S_PKT_FRAMER_CRC_EN
  logic [7:0] crc_q, crc_src, crc_byte, crc_nxt;
  logic       crc_load, trunc_q;

  // MAGIC is folded in on tag acceptance, starting from the zero init value.
  always_comb begin
    crc_src  = (state_q == StIdle) ? 8'h00 : crc_q;
    crc_byte = (state_q == StIdle) ? MAGIC :
               (state_q == StHdr)  ? hdr_byte : s_axis_tdata;
  end

  assign crc_load = tag_ok || ((state_q == StHdr) && out_free) ||
                    ((state_q == StPayload) && in_fire);

  crc8_07 u_crc8 (
    .crc_i  (crc_src),
    .data_i (crc_byte),
    .crc_o  (crc_nxt)
  );

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      crc_q <= '0;
    end else if (crc_load) begin
      crc_q <= crc_nxt;
    end
  end
`endif

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= StIdle;
      tag_q       <= '0;
      hdr_idx_q   <= '0;
      cnt_q       <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_user_q  <= 1'b0;
      for (int i = 0; i < int'(CN); i++) begin
        seq_q[i] <= '0;
      end
`ifdef I2S_PKT_FRAMER_CRC_EN
      trunc_q     <= 1'b0;
`endif
    end else begin
      if (out_free) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        StIdle: begin
          if (in_fire) begin
            tag_q <= tag_in;
            if (tag_ok) begin
              out_valid_q <= 1'b1;
              out_data_q  <= MAGIC;
              out_last_q  <= 1'b0;
              out_user_q  <= 1'b0;
              hdr_idx_q   <= 3'd1;
              state_q     <= StHdr;
            end else begin
              drop_cnt_q <= drop_cnt_q + 16'd1;
              state_q    <= s_axis_tlast ? StIdle : StDrop;
            end
          end
        end
        StHdr: begin
          if (out_free) begin
            out_valid_q <= 1'b1;
            out_data_q  <= hdr_byte;
            out_last_q  <= 1'b0;
            out_user_q  <= 1'b0;
            hdr_idx_q   <= hdr_idx_q + 3'd1;
            if (hdr_idx_q == 3'(HdrLen - 1)) begin
              cnt_q   <= '0;
              state_q <= StPayload;
            end
          end
        end
        StPayload: begin
          if (in_fire) begin
            out_valid_q <= 1'b1;
            out_data_q  <= s_axis_tdata;
            out_last_q  <= 1'b0;
            out_user_q  <= 1'b0;
            cnt_q       <= cnt_inc;
            if (s_axis_tlast || (cnt_inc == MaxPl)) begin
`ifdef I2S_PKT_FRAMER_CRC_EN
              trunc_q <= !s_axis_tlast;
              state_q <= StCrc;
`else
              out_last_q     <= 1'b1;
              out_user_q     <= !s_axis_tlast;
              seq_q[ch_idx]  <= seq_cur + 16'd1;
              if (s_axis_tlast) begin
                frame_cnt_q <= frame_cnt_q + 32'd1;
                state_q     <= StIdle;
              end else begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
                state_q    <= StDrop;
              end
`endif
            end
          end
        end
`ifdef I2S_PKT_FRAMER_CRC_EN
        StCrc: begin
          if (out_free) begin
            out_valid_q   <= 1'b1;
            out_data_q    <= crc_q;
            out_last_q    <= 1'b1;
            out_user_q    <= trunc_q;
            seq_q[ch_idx] <= seq_cur + 16'd1;
            if (trunc_q) begin
              drop_cnt_q <= drop_cnt_q + 16'd1;
              state_q    <= StDrop;
            end else begin
              frame_cnt_q <= frame_cnt_q + 32'd1;
              state_q     <= StIdle;
            end
          end
        end
`endif
        StDrop: begin
          if (in_fire && s_axis_tlast) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tuser  = out_user_q;
  assign o_frame_count = frame_cnt_q;
  assign o_drop_count  = drop_cnt_q;

endmodule

// File: tb/tb_i2s_pkt_framer.sv
// Scoreboard bench for i2s_pkt_framer: packet-level reference model feeds an expected-byte
// queue; a negedge monitor pops and compares on every output handshake.
module tb_i2s_pkt_framer;

  localparam int         CN    = 8;
  localparam int         MAXP  = 64;
  localparam logic [7:0] MAGIC = 8'h5A;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       u;
  } exp_t;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic        s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [7:0]  s_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        i_enable;
  logic [31:0] o_frame_count;
  logic [15:0] o_drop_count;

  int          n_checks = 0;
  int          n_err    = 0;
  exp_t        exp_q[$];
  logic [15:0] m_seq[16];
  int          m_frame = 0;
  int          m_drop  = 0;
  bit          sb_off  = 1'b0;
  bit          bp_en   = 1'b0;
  bit          prev_stall = 1'b0;
  logic [7:0]  held_d;
  logic        held_l, held_u;

  i2s_pkt_framer #(
    .CN          (CN),
    .MAX_PAYLOAD (MAXP),
    .MAGIC       (MAGIC)
  ) dut (
    .sys_clk       (sys_clk),
    .rst           (rst),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tready (m_axis_tready),
    .i_enable      (i_enable),
    .o_frame_count (o_frame_count),
    .o_drop_count  (o_drop_count)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    #1;
    m_axis_tready = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Bit-serial CRC-8, poly 0x07, MSB first.
  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic fb;
    for (int b = 7; b >= 0; b--) begin
      fb = c[7] ^ d[b];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  function automatic void model_frame(input logic [7:0] tag, input bq_t pl, input bit en);
    logic [3:0] dst = tag[7:4];
    logic [3:0] ch  = tag[3:0];
    bq_t        pk;
    bit         trunc;
    int         k;
    logic [7:0] c;
    exp_t       e;
    if (pl.size() == 0 || int'(ch) >= CN || !en) begin
      m_drop++;
      return;
    end
    pk.push_back(MAGIC);
    pk.push_back({4'h0, dst});
    pk.push_back({4'h0, ch});
    pk.push_back(m_seq[ch][15:8]);
    pk.push_back(m_seq[ch][7:0]);
    trunc = pl.size() > MAXP;
    k     = trunc ? MAXP : pl.size();
    for (int i = 0; i < k; i++) pk.push_back(pl[i]);
`ifdef I2S_PKT_FRAMER_CRC_EN
    c = 8'h00;
    foreach (pk[i]) c = crc8(c, pk[i]);
    pk.push_back(c);
`else
    c = 8'h00;
`endif
    foreach (pk[i]) begin
      e.d = pk[i];
      e.l = (i == pk.size() - 1);
      e.u = (i == pk.size() - 1) && trunc;
      exp_q.push_back(e);
    end
    m_seq[ch] = m_seq[ch] + 16'd1;
    if (trunc) m_drop++;
    else m_frame++;
  endfunction

  // Monitor: outputs are stable from posedge+0 to next posedge, so the negedge sees the
  // values that will handshake.
  always @(negedge sys_clk) begin
    exp_t e;
    if (rst || sb_off) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_checks++;
        if (!m_axis_tvalid || m_axis_tdata !== held_d || m_axis_tlast !== held_l ||
            m_axis_tuser !== held_u) begin
          n_err++;
          $display("FAIL stall_hold got v=%b d=%h l=%b u=%b want v=1 d=%h l=%b u=%b",
                   m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser,
                   held_d, held_l, held_u);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_byte got d=%h l=%b u=%b want none",
                   m_axis_tdata, m_axis_tlast, m_axis_tuser);
        end else begin
          e = exp_q.pop_front();
          if (m_axis_tdata !== e.d || m_axis_tlast !== e.l || m_axis_tuser !== e.u) begin
            n_err++;
            $display("FAIL out_byte got d=%h l=%b u=%b want d=%h l=%b u=%b",
                     m_axis_tdata, m_axis_tlast, m_axis_tuser, e.d, e.l, e.u);
          end
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      held_d     = m_axis_tdata;
      held_l     = m_axis_tlast;
      held_u     = m_axis_tuser;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the byte is accepted.
  task automatic put_byte(input logic [7:0] d, input logic l, input bit chk_rdy);
    int t = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    @(negedge sys_clk);
    if (chk_rdy) begin
      n_checks++;
      if (!s_axis_tready) begin
        n_err++;
        $display("FAIL drop_ready got=%b want=1", s_axis_tready);
      end
    end
    while (!s_axis_tready && t < 300) begin
      @(negedge sys_clk);
      t++;
    end
    if (!s_axis_tready) begin
      n_checks++;
      n_err++;
      $display("FAIL in_timeout got tready=0 want tready=1 within 300 cycles");
    end
    @(posedge sys_clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 8'h00;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] tag, input bq_t pl, input bit en);
    bit drop_tag = (pl.size() == 0) || (int'(tag[3:0]) >= CN) || !en;
    model_frame(tag, pl, en);
    i_enable = en;
    put_byte(tag, pl.size() == 0, 1'b0);
    i_enable = ($urandom_range(0, 1) == 1);
    foreach (pl[i]) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge sys_clk);
        #1;
      end
      put_byte(pl[i], i == pl.size() - 1, drop_tag);
    end
  endtask

  function automatic bq_t mk_pl(input int n, input bit rnd);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(rnd ? 8'($urandom) : 8'(i + 1));
    return q;
  endfunction

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && t < 3000) begin
      @(negedge sys_clk);
      t++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain got pending=%0d want pending=0", exp_q.size());
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk_counts();
    n_checks += 2;
    if (o_frame_count !== 32'(m_frame)) begin
      n_err++;
      $display("FAIL frame_count got=%0d want=%0d", o_frame_count, m_frame);
    end
    if (o_drop_count !== 16'(m_drop)) begin
      n_err++;
      $display("FAIL drop_count got=%0d want=%0d", o_drop_count, m_drop);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 8'h00;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    i_enable      = 1'b1;
    foreach (m_seq[i]) m_seq[i] = 16'h0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    n_checks += 6;
    if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid got=%b want=0", m_axis_tvalid); end
    if (m_axis_tdata !== 8'h00) begin n_err++; $display("FAIL rst_tdata got=%h want=00", m_axis_tdata); end
    if (m_axis_tlast !== 1'b0) begin n_err++; $display("FAIL rst_tlast got=%b want=0", m_axis_tlast); end
    if (m_axis_tuser !== 1'b0) begin n_err++; $display("FAIL rst_tuser got=%b want=0", m_axis_tuser); end
    if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL rst_sready got=%b want=0", s_axis_tready); end
    if (o_frame_count !== 32'd0 || o_drop_count !== 16'd0) begin
      n_err++;
      $display("FAIL rst_counts got=%0d/%0d want=0/0", o_frame_count, o_drop_count);
    end
    @(posedge sys_clk);
    #1;
    rst = 1'b0;

    // Basic frame, then sequence progression on ch 3 with an interleaved ch 5.
    send_frame(8'h23, mk_pl(4, 1'b0), 1'b1);
    drain();
    chk_counts();
    send_frame(8'h23, mk_pl(4, 1'b0), 1'b1);
    send_frame(8'h25, mk_pl(3, 1'b1), 1'b1);
    send_frame(8'h23, mk_pl(2, 1'b1), 1'b1);
    drain();
    chk_counts();

    // Truncation and the exact-length boundary.
    send_frame(8'h23, mk_pl(70, 1'b0), 1'b1);
    send_frame(8'h14, mk_pl(MAXP, 1'b1), 1'b1);
    drain();
    chk_counts();

    // Discarded tags: out-of-range channel, tag-only, disabled.
    send_frame(8'h1F, mk_pl(3, 1'b1), 1'b1);
    send_frame(8'h12, mk_pl(0, 1'b1), 1'b1);
    send_frame(8'h12, mk_pl(3, 1'b1), 1'b0);
    drain();
    chk_counts();

    // Randomized traffic under 50% backpressure.
    bp_en = 1'b1;
    for (int f = 0; f < 40; f++) begin
      send_frame({4'($urandom), 4'($urandom_range(0, 9))},
                 mk_pl($urandom_range(0, 75), 1'b1), $urandom_range(0, 7) != 0);
    end
    drain();
    chk_counts();
    bp_en = 1'b0;

    // Reset mid-payload aborts the packet and clears all counters.
    sb_off = 1'b1;
    i_enable = 1'b1;
    put_byte(8'h13, 1'b0, 1'b0);
    put_byte(8'hA1, 1'b0, 1'b0);
    put_byte(8'hA2, 1'b0, 1'b0);
    n_checks++;
    if (m_axis_tvalid !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_tvalid got=%b want=1", m_axis_tvalid);
    end
    rst = 1'b1;
    @(posedge sys_clk);
    #1;
    n_checks += 2;
    if (m_axis_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_tvalid got=%b want=0", m_axis_tvalid);
    end
    if (o_frame_count !== 32'd0 || o_drop_count !== 16'd0) begin
      n_err++;
      $display("FAIL midrst_counts got=%0d/%0d want=0/0", o_frame_count, o_drop_count);
    end
    @(posedge sys_clk);
    #1;
    rst = 1'b0;
    foreach (m_seq[i]) m_seq[i] = 16'h0;
    m_frame = 0;
    m_drop  = 0;
    exp_q.delete();
    sb_off = 1'b0;
    send_frame(8'h23, mk_pl(2, 1'b1), 1'b1);
    drain();
    chk_counts();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
